tick_gen_ctrl: RTL and testbench

- Upstream enable/tick source for the LED counter stage. The counter increments only on `tick`.
- Provides a prescaled run rate and a debounced run/stop pushbutton, plus a single-step pushbutton for manual stepping while stopped.
- Sits between the board pushbuttons/clock and the counter's increment enable.

---
 rtl/tick_gen_ctrl_if.sv | 13 +
 rtl/tick_gen_ctrl.sv | 125 ++++++++++++
 tb/tb_tick_gen_ctrl.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/tick_gen_ctrl_if.sv
// Board-side signal bundle for the tick generator: raw pushbuttons in,
// counter increment enable and status levels out.
interface tick_gen_ctrl_if;
    logic btn_run;
    logic btn_step;
    logic tick;
    logic running;
    logic run_db;
    logic step_db;

    modport master (output btn_run, btn_step, input tick, running, run_db, step_db);
    modport slave  (input btn_run, btn_step, output tick, running, run_db, step_db);
endinterface

// File: rtl/tick_gen_ctrl.sv
// Run/stop and single-step tick source for the LED counter: per-button
// synchronizer + debouncer, a two-state run FSM and a DIV-cycle prescaler.

module tick_gen_db #(
    parameter int DB_CYCLES = 500000,
    parameter int CW        = 20
) (
    input  logic inclk,
    input  logic rst_n,
    input  logic btn,
    output logic db,
    output logic fall
);
    logic [1:0]    sync;
    logic [CW-1:0] cnt;
    logic          lvl;

    assign lvl = sync[1];

    always_ff @(posedge inclk or negedge rst_n) begin
        if (!rst_n) begin
            sync <= 2'b11;
            cnt  <= '0;
            db   <= 1'b1;
            fall <= 1'b0;
        end else begin
            sync <= {sync[0], btn};
            fall <= 1'b0;
            if (lvl == db) begin
                cnt <= '0;
            end else if (cnt == CW'(DB_CYCLES - 1)) begin
                // Level held long enough: accept it; only a 1->0 edge is an event.
                cnt  <= '0;
                db   <= lvl;
                fall <= db;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end
endmodule

module tick_gen_ctrl #(
    parameter int DIV       = 6250000,
    parameter int DB_CYCLES = 500000
) (
    input  logic           inclk,
    input  logic           rst_n,
    tick_gen_ctrl_if.slave bus
);
    function automatic int clogb2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++)
            if ((1 << i) < v) r = i + 1;
        return r;
    endfunction

    localparam int NUM_BTN = 2;
    localparam int DW      = clogb2(DIV);
    localparam int CW      = clogb2(DB_CYCLES) + 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);

    typedef enum logic {STOPPED, RUNNING} state_t;

    // Lane 0 = run button, lane 1 = step button.
    logic [NUM_BTN-1:0] btn_raw;
    logic [NUM_BTN-1:0] db_lvl;
    logic [NUM_BTN-1:0] press;

    assign btn_raw = {bus.btn_step, bus.btn_run};

    tick_gen_db #(.DB_CYCLES(DB_CYCLES), .CW(CW)) u_db [NUM_BTN-1:0] (
        .inclk (inclk),
        .rst_n (rst_n),
        .btn   (btn_raw),
        .db    (db_lvl),
        .fall  (press)
    );

    state_t        state;
    logic [DW-1:0] div_cnt;
    logic          tick_r;

    always_ff @(posedge inclk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= STOPPED;
            div_cnt <= '0;
            tick_r  <= 1'b0;
        end else begin
            case (state)
                STOPPED: begin
                    div_cnt <= '0;
                    if (press[0]) begin
                        state  <= RUNNING;
                        tick_r <= 1'b0;
                    end else begin
                        tick_r <= press[1];
                    end
                end
                RUNNING: begin
                    // Step presses are ignored while running.
                    if (press[0]) begin
                        state   <= STOPPED;
                        div_cnt <= '0;
                        tick_r  <= 1'b0;
                    end else begin
                        tick_r  <= (div_cnt == DIV_LAST);
                        div_cnt <= (div_cnt == DIV_LAST) ? '0 : div_cnt + 1'b1;
                    end
                end
                default: begin
                    state   <= STOPPED;
                    div_cnt <= '0;
                    tick_r  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.tick    = tick_r;
    assign bus.running = (state == RUNNING);
    assign bus.run_db  = db_lvl[0];
    assign bus.step_db = db_lvl[1];
endmodule

// File: tb/tb_tick_gen_ctrl.sv
// Random and directed stimulus for tick_gen_ctrl, checked each cycle against
// a window-based behavioural model of debounce, run/stop and prescaling.
module tb_tick_gen_ctrl;
    localparam int DIV = 4;
    localparam int DB  = 3;

    logic inclk = 1'b0;
    logic rst_n = 1'b1;
    tick_gen_ctrl_if bus();

    tick_gen_ctrl #(.DIV(DIV), .DB_CYCLES(DB)) dut (
        .inclk (inclk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 inclk = ~inclk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, act, exp);
        end
    endtask

    // Model: raw samples reach the debouncer two edges late; the debounced
    // level flips once the last DB seen samples all disagree with it.
    bit          d1 [2], d2 [2], db [2], prs [2];
    bit [DB-1:0] win [2];
    bit          m_run, m_tick;
    int          k;

    int  ticks, rises;
    bit  prev_run;

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            d1[i] = 1; d2[i] = 1; db[i] = 1; prs[i] = 0; win[i] = '1;
        end
        m_run = 0; m_tick = 0; k = 0; prev_run = 0;
    endtask

    task automatic model_edge(input bit r, input bit s);
        bit [1:0] raw;
        bit       seen;
        raw = {s, r};
        if (m_run) begin
            if (prs[0]) begin m_run = 0; m_tick = 0; end
            else begin k++; m_tick = (k % DIV == 0); end
        end else begin
            if (prs[0]) begin m_run = 1; k = 0; m_tick = 0; end
            else m_tick = prs[1];
        end
        for (int i = 0; i < 2; i++) begin
            seen   = d2[i];
            d2[i]  = d1[i];
            d1[i]  = raw[i];
            win[i] = {win[i][DB-2:0], seen};
            prs[i] = 0;
            if (win[i] == {DB{~db[i]}}) begin
                prs[i] = db[i];
                db[i]  = ~db[i];
            end
        end
    endtask

    task automatic cyc();
        @(posedge inclk);
        model_edge(bus.btn_run, bus.btn_step);
        #1;
        chk("cyc", {bus.tick, bus.running, bus.run_db, bus.step_db},
            {m_tick, m_run, db[0], db[1]});
        ticks += int'(bus.tick);
        if (bus.running && !prev_run) rises++;
        prev_run = bus.running;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        chk("rst", {bus.tick, bus.running, bus.run_db, bus.step_db}, 4'b0011);
        model_reset();
        repeat (2) @(posedge inclk);
        #1 rst_n = 1'b1;
    endtask

    task automatic hold(input bit r, input bit s, input int n);
        bus.btn_run  = r;
        bus.btn_step = s;
        repeat (n) cyc();
    endtask

    int  lat, e_run, e_tick, post, t0, got;
    bit  fell, ran;

    initial begin
        bus.btn_run  = 1'b1;
        bus.btn_step = 1'b1;
        #2;
        do_reset();
        hold(1, 1, 50);
        chk("idle_ticks", ticks, 0);

        // Start: latency to debounced level, then first tick DIV after running.
        lat = 0; e_run = 0; e_tick = 0;
        bus.btn_run = 1'b0;
        for (int n = 1; n <= 40; n++) begin
            if (n == 11) bus.btn_run = 1'b1;
            cyc();
            if (!bus.run_db && lat == 0) lat = n;
            if (bus.running && e_run == 0) e_run = n;
            if (bus.tick && e_tick == 0) e_tick = n;
        end
        chk("db_latency", lat, DB + 2);
        chk("first_tick_gap", e_tick - e_run, DIV);

        // Stop: no ticks once running has dropped.
        post = 0;
        bus.btn_run = 1'b0;
        for (int n = 1; n <= 30; n++) begin
            if (n == 11) bus.btn_run = 1'b1;
            cyc();
            if (!bus.running) post += int'(bus.tick);
        end
        chk("stop_quiet", post, 0);
        chk("stopped", bus.running, 1'b0);

        // Bounce shorter than DB never changes the debounced level.
        fell = 0;
        for (int n = 0; n < 6; n++) begin
            bus.btn_run = 1'b0; cyc(); cyc(); fell |= !bus.run_db;
            bus.btn_run = 1'b1; cyc(); cyc(); fell |= !bus.run_db;
        end
        hold(1, 1, 6);
        chk("bounce_db", fell, 1'b0);
        chk("bounce_run", bus.running, 1'b0);

        // Single steps while stopped.
        t0 = ticks; ran = 0;
        for (int n = 0; n < 3; n++) begin
            bus.btn_step = 1'b0;
            repeat (6) begin cyc(); ran |= bus.running; end
            bus.btn_step = 1'b1;
            repeat (8) begin cyc(); ran |= bus.running; end
        end
        chk("step_ticks", ticks - t0, 3);
        chk("step_stopped", ran, 1'b0);

        // Step while running is ignored; the model checks the cadence.
        hold(0, 1, 6); hold(1, 1, 20);
        hold(1, 0, 6); hold(1, 1, 14);
        chk("run_step", bus.running, 1'b1);
        hold(0, 1, 6); hold(1, 1, 14);

        // Simultaneous run + step while stopped: run wins, no step tick.
        e_run = 0; e_tick = 0;
        bus.btn_run = 1'b0; bus.btn_step = 1'b0;
        for (int n = 1; n <= 25; n++) begin
            if (n == 7) begin bus.btn_run = 1'b1; bus.btn_step = 1'b1; end
            cyc();
            if (bus.running && e_run == 0) e_run = n;
            if (bus.tick && e_tick == 0) e_tick = n;
        end
        chk("both_running", bus.running, 1'b1);
        chk("both_gap", e_tick - e_run, DIV);
        hold(0, 1, 6); hold(1, 1, 10);

        // Random button activity.
        for (int n = 0; n < 60; n++)
            hold(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom_range(1, 9));
        hold(1, 1, 12);

        // Asynchronous reset while a tick is high.
        do_reset();
        hold(0, 1, 6);
        bus.btn_run = 1'b1;
        got = 0;
        for (int n = 0; n < 20 && got == 0; n++) begin
            cyc();
            if (bus.tick) got = 1;
        end
        chk("tick_seen", got, 1);
        #2 rst_n = 1'b0;
        #1 chk("async_rst", {bus.tick, bus.running, bus.run_db, bus.step_db}, 4'b0011);
        model_reset();
        repeat (2) @(posedge inclk);
        #1 rst_n = 1'b1;
        t0 = ticks;
        hold(1, 1, 25);
        chk("post_rst_ticks", ticks - t0, 0);
        chk("post_rst_run", bus.running, 1'b0);

        // Run button held low through reset release: exactly one event.
        bus.btn_run = 1'b0;
        do_reset();
        rises = 0;
        hold(0, 1, 15);
        hold(1, 1, 15);
        chk("held_rst_events", rises, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
